riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency unified memory between the pipeline's IF port (fetch) and MEM port (LW/SW).
//  Sits between the RISC-V pipeline and memory; replaces the separate IMemory/DMemory arrays.
//  One access is in flight at a time; a requester with no grant stalls its pipeline stage.
//  Data port wins by default because it holds the older instruction; an optional guard bounds fetch starvation.
// PARAMETERS
//  AW          32  address width (byte address; word index = addr >> 2 is formed by the memory)
//  DW          32  data width
//  MEM_LAT     2   cycles from the mem_en cycle to mem_rdata valid; legal range >= 1
//  STARVE_MAX  4   consecutive data grants allowed while if_req is pending (used only with ARB_FAIRNESS_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  if_req     in   1   fetch request; held with if_addr until if_gnt
//  if_addr    in   AW  fetch address (the PC)
//  if_gnt     out  1   fetch request accepted this cycle
//  if_rvalid  out  1   if_rdata valid; 1-cycle pulse
//  if_rdata   out  DW  fetched instruction
//  d_req      in   1   data request; held with d_we, d_addr, d_wdata until d_gnt
//  d_we       in   1   1 = SW, 0 = LW
//  d_addr     in   AW  data address (EXMEM ALU result)
//  d_wdata    in   DW  store data
//  d_gnt      out  1   data request accepted this cycle
//  d_rvalid   out  1   load data valid, or store complete; 1-cycle pulse
//  d_rdata    out  DW  load data; 0 for a store
//  mem_en     out  1   memory access strobe, 1 cycle per access
//  mem_we     out  1   write enable, qualified by mem_en
//  mem_addr   out  AW  access address
//  mem_wdata  out  DW  write data
//  mem_rdata  in   DW  read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  FSM states:
//   - IDLE: no access in flight.
//   - WAIT: access in flight; lat_cnt counts MEM_LAT down to 1.
//  IDLE with a request:
//   - pick the winner; assert its gnt and mem_en in the same cycle (combinational from req and state).
//   - mem_addr/we/wdata come from the winner; the owner register is loaded; go to WAIT.
//   - mem_we is always 0 for a fetch.
//  WAIT:
//   - when lat_cnt == 1, assert the owner's rvalid and drive its rdata from mem_rdata (or 0 for a store).
//   - return to IDLE on the next edge.
//   - no gnt and no mem_en while in WAIT.
//  Timing:
//   - grant-to-rvalid latency = MEM_LAT cycles.
//   - throughput = one access per MEM_LAT+1 cycles.
//   - a req held through an rvalid cycle can be granted in the following IDLE cycle at the earliest.
//  Priority:
//   - d_req beats if_req.
//   - a req dropped before its gnt has no effect.
//   - changing addr/we/wdata while req=1 and gnt=0 is illegal; the bench asserts this never happens.
//  Simultaneous if_req and d_req in IDLE: data is granted; fetch waits (no fetch grant that cycle).
//  Idle outputs: mem_en, both gnt and both rvalid are 0; mem_addr, mem_we and mem_wdata are 0 when mem_en = 0.
//  Reset (asynchronous, any cycle):
//   - state = IDLE, owner = NONE, lat_cnt = 0, starve_cnt = 0.
//   - all outputs 0.
//   - an access in flight is abandoned; its late mem_rdata is ignored (no rvalid is produced).
//   - first grant possible in the first cycle after reset deasserts.
// CONFIGURATION
//  ARB_FAIRNESS_EN defined:
//   - starve_cnt increments on each data grant made while if_req = 1.
//   - it clears on a fetch grant, or in any IDLE cycle with if_req = 0.
//   - when starve_cnt == STARVE_MAX, the next IDLE arbitration grants fetch even if d_req = 1.
//  ARB_FAIRNESS_EN undefined: strict data priority; starve_cnt is not built.
// STRUCTURE
//  Package riscv_arb_pkg:
//   - owner_t {OWN_NONE, OWN_IF, OWN_D}
//   - state_t {ST_IDLE, ST_WAIT}
//   - opcode constants LW = 7'b000_0011, SW = 7'b010_0011 (shared with the pipeline)
//  Sub-module riscv_arb_select: combinational winner pick from if_req, d_req and the starvation flag.
//   - returns owner_t.
//  FSM, counters and output muxing stay in riscv_mem_arbiter.
// TESTING (MEM_LAT=2, STARVE_MAX=4)
//  1. Single fetch: if_req, if_addr=0x10 at cycle 0.
//     -> if_gnt and mem_en at c0 with mem_addr=0x10 and mem_we=0.
//     -> if_rvalid at c2 with if_rdata = mem_rdata.
//     -> next grant possible at c3.
//  2. Store, then load: SW addr 0x40 wdata 0xDEADBEEF, then LW addr 0x40.
//     -> d_rvalid at c2 with d_rdata = 0.
//     -> LW granted at c3; d_rvalid at c5 with d_rdata = 0xDEADBEEF.
//  3. Contention: if_req and d_req both high at c0.
//     -> d_gnt at c0, if_gnt 0.
//     -> if_gnt at c3; if_rvalid at c5.
//  4. Fairness ON: d_req and if_req held high continuously.
//     -> four d_gnts (c0, c3, c6, c9), then if_gnt at c12.
//     Fairness OFF, same stimulus: if_gnt never asserts.
//  5. Reset mid-access: assert reset at c1 after a c0 data grant.
//     -> d_rvalid never pulses; all outputs 0 during reset.
//     -> a new d_req is granted in the first cycle after reset deasserts.
//  6. Req withdrawn: if_req pulses for one cycle during WAIT.
//     -> no if_gnt; no extra mem_en.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// Shared types for the unified-memory arbiter: owner and FSM encodings,
// plus the load/store opcodes the pipeline decodes into d_we.
// No logic; imported by the arbiter, its selector and the bench.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [6:0] LW = 7'b000_0011;
  localparam logic [6:0] SW = 7'b010_0011;

endpackage

// File: rtl/riscv_arb_select.sv
// Winner pick between fetch and data requests; data wins unless starving.
// Latency: purely combinational (0 cycles).
// Backpressure: none; caller masks requests when no grant may be issued.
import riscv_arb_pkg::*;

module riscv_arb_select (
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   starve_i,
  output owner_t winner_o
);

  // Starved fetch first, then the older data access, then fetch.
  always_comb begin
    winner_o = OWN_NONE;
    if (starve_i && if_req_i) begin
      winner_o = OWN_IF;
    end else if (d_req_i) begin
      winner_o = OWN_D;
    end else if (if_req_i) begin
      winner_o = OWN_IF;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store ports.
// Latency: grant and mem_en in the request cycle; rvalid MEM_LAT cycles later.
// Backpressure: one access in flight; unserved requesters hold req until gnt.
// Optional fetch-starvation guard: define ARB_FAIRNESS_EN.
import riscv_arb_pkg::*;

module riscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int LCW = $clog2(MEM_LAT + 1);

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  logic [LCW-1:0] lat_cnt_q, lat_cnt_d;
  logic           we_q, we_d;      // in-flight data access is a store
  logic           arb_en;
  logic           starve_hit;
  owner_t         winner;

  // Grants only from IDLE and never while reset is held, so outputs stay 0.
  assign arb_en = (state_q == ST_IDLE) && !reset_i;

`ifdef ARB_FAIRNESS_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q == SCW'(STARVE_MAX));

  // Count data grants that bypass a waiting fetch; clear once fetch is served or gone.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en) begin
      if (winner == OWN_IF || !if_req_i) begin
        starve_cnt_d = '0;
      end else if (winner == OWN_D) begin
        starve_cnt_d = starve_cnt_q + SCW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  riscv_arb_select u_select (
    .if_req_i (if_req_i && arb_en),
    .d_req_i  (d_req_i && arb_en),
    .starve_i (starve_hit),
    .winner_o (winner)
  );

  // FSM next state plus grant, memory strobe and response muxing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    we_d        = we_q;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          mem_en_o  = 1'b1;
          owner_d   = winner;
          lat_cnt_d = LCW'(MEM_LAT);
          state_d   = ST_WAIT;
          if (winner == OWN_D) begin
            d_gnt_o     = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            we_d        = d_we_i;
          end else begin
            if_gnt_o   = 1'b1;
            mem_addr_o = if_addr_i;
            we_d       = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == LCW'(1)) begin
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          lat_cnt_d = '0;
          we_d      = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end else if (owner_q == OWN_D) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = we_q ? '0 : mem_rdata_i;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // FSM and in-flight access registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      lat_cnt_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      we_q      <= we_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a queue-based scoreboard.
// Stimulus pushes hand-computed grant/rvalid events; a negedge monitor pops them.
// Memory model returns 0x1000_0000 | addr for locations never written.
import riscv_arb_pkg::*;

module tb_riscv_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;

  typedef enum int {K_IFG, K_DG, K_IFR, K_DR} kind_e;
  typedef struct {
    kind_e       kind;
    int          cyc;
    logic [31:0] val;   // mem_addr for grants, rdata for rvalids
    logic        we;
    logic [31:0] wd;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        done = 1'b0;
  logic [31:0] mem_arr [int unsigned];
  logic [31:0] pipe [MEM_LAT];

  riscv_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 32'h1000_0000 | a;
  endfunction

  // Fixed-latency memory: data for a mem_en cycle appears MEM_LAT cycles later.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    pipe[0] <= mem_en ? mem_rd(mem_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  task automatic add_exp(input kind_e k, input int c, input logic [31:0] v,
                         input logic w, input logic [31:0] wd);
    exp_t e;
    e.kind = k; e.cyc = c; e.val = v; e.we = w; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic chk_evt(input kind_e k, input logic [31:0] v,
                         input logic w, input logic [31:0] wd);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s at cycle %0d: got val=%h we=%b wd=%h, none expected",
               k.name(), cyc, v, w, wd);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v || e.we != w || e.wd != wd) begin
        n_fail++;
        $display("FAIL event: got %s cyc=%0d val=%h we=%b wd=%h, expected %s cyc=%0d val=%h we=%b wd=%h",
                 k.name(), cyc, v, w, wd, e.kind.name(), e.cyc, e.val, e.we, e.wd);
      end
    end
  endtask

  // Monitor: sample away from the active edge, check events and idle rules.
  always @(negedge clk) begin
    if (done) begin
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_events: got %0d pending, expected 0 (next %s at cycle %0d)",
                 exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end else if (reset) begin
      n_chk++;
      if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata} != '0) begin
        n_fail++;
        $display("FAIL reset_outputs at cycle %0d: got gnt=%b%b rv=%b%b en=%b addr=%h, expected all 0",
                 cyc, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_addr);
      end
    end else begin
      if (if_gnt)    chk_evt(K_IFG, mem_addr, mem_we, mem_wdata);
      if (d_gnt)     chk_evt(K_DG,  mem_addr, mem_we, mem_wdata);
      if (if_rvalid) chk_evt(K_IFR, if_rdata, 1'b0, 32'h0);
      if (d_rvalid)  chk_evt(K_DR,  d_rdata,  1'b0, 32'h0);
      n_chk++;
      if (mem_en != (if_gnt || d_gnt) || (if_gnt && d_gnt) ||
          (!mem_en && {mem_we, mem_addr, mem_wdata} != '0)) begin
        n_fail++;
        $display("FAIL strobe_rules at cycle %0d: got en=%b gnt=%b%b we=%b addr=%h wd=%h, expected en=gnt, one gnt, 0 when idle",
                 cyc, mem_en, if_gnt, d_gnt, mem_we, mem_addr, mem_wdata);
      end
      if (!if_rvalid && if_rdata != '0) begin
        n_chk++; n_fail++;
        $display("FAIL if_rdata_idle at cycle %0d: got %h, expected 0", cyc, if_rdata);
      end
      if (!d_rvalid && d_rdata != '0) begin
        n_chk++; n_fail++;
        $display("FAIL d_rdata_idle at cycle %0d: got %h, expected 0", cyc, d_rdata);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [6:0] op, input logic [31:0] a, input logic [31:0] wd);
    d_req   = 1'b1;
    d_we    = (op == SW);
    d_addr  = a;
    d_wdata = wd;
  endtask

  task automatic clear_d();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic clear_if();
    if_req = 1'b0; if_addr = '0;
  endtask

  initial begin
    int b;
    reset = 1'b1;
    clear_if();
    clear_d();
    step(3);
    reset = 1'b0;
    step(2);

    // 1. Single fetch.
    b = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    add_exp(K_IFG, b,     32'h10,        1'b0, 32'h0);
    add_exp(K_IFR, b + 2, 32'h1000_0010, 1'b0, 32'h0);
    step(1); clear_if();
    step(3);

    // 2. Store then load of the same word; load requested in the rvalid cycle.
    b = cyc;
    drive_d(SW, 32'h40, 32'hDEAD_BEEF);
    add_exp(K_DG, b,     32'h40, 1'b1, 32'hDEAD_BEEF);
    add_exp(K_DR, b + 2, 32'h0,  1'b0, 32'h0);
    step(1); clear_d();
    step(1); drive_d(LW, 32'h40, 32'h0);
    add_exp(K_DG, b + 3, 32'h40,        1'b0, 32'h0);
    add_exp(K_DR, b + 5, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(2); clear_d();
    step(2);

    // 3. Contention: data first, fetch right after.
    b = cyc;
    if_req = 1'b1; if_addr = 32'h20;
    drive_d(LW, 32'h80, 32'h0);
    add_exp(K_DG,  b,     32'h80,        1'b0, 32'h0);
    add_exp(K_DR,  b + 2, 32'h1000_0080, 1'b0, 32'h0);
    add_exp(K_IFG, b + 3, 32'h20,        1'b0, 32'h0);
    add_exp(K_IFR, b + 5, 32'h1000_0020, 1'b0, 32'h0);
    step(1); clear_d();
    step(3); clear_if();
    step(2);

    // 4. Both requests held: fetch starvation behaviour.
    b = cyc;
    if_req = 1'b1; if_addr = 32'h30;
    drive_d(LW, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      add_exp(K_DG, b + 3*k,     32'h100,       1'b0, 32'h0);
      add_exp(K_DR, b + 3*k + 2, 32'h1000_0100, 1'b0, 32'h0);
    end
`ifdef ARB_FAIRNESS_EN
    add_exp(K_IFG, b + 12, 32'h30,        1'b0, 32'h0);
    add_exp(K_IFR, b + 14, 32'h1000_0030, 1'b0, 32'h0);
`else
    add_exp(K_DG,  b + 12, 32'h100,       1'b0, 32'h0);
    add_exp(K_DR,  b + 14, 32'h1000_0100, 1'b0, 32'h0);
`endif
    add_exp(K_DG, b + 15, 32'h100,       1'b0, 32'h0);
    add_exp(K_DR, b + 17, 32'h1000_0100, 1'b0, 32'h0);
    step(13); clear_if();
    step(3);  clear_d();
    step(2);

    // 5. Reset during an access; new request waits through reset.
    b = cyc;
    drive_d(LW, 32'h40, 32'h0);
    add_exp(K_DG, b, 32'h40, 1'b0, 32'h0);
    step(1); clear_d(); reset = 1'b1;
    step(1); drive_d(LW, 32'h44, 32'h0);
    step(1); reset = 1'b0;
    add_exp(K_DG, b + 3, 32'h44,        1'b0, 32'h0);
    add_exp(K_DR, b + 5, 32'h1000_0044, 1'b0, 32'h0);
    step(1); clear_d();
    step(2);

    // 6. Fetch request withdrawn while the memory is busy.
    b = cyc;
    drive_d(LW, 32'h40, 32'h0);
    add_exp(K_DG, b,     32'h40,        1'b0, 32'h0);
    add_exp(K_DR, b + 2, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(1); clear_d(); if_req = 1'b1; if_addr = 32'h50;
    step(1); clear_if();
    step(3);

    done = 1'b1;
    step(5);
    $display("FAIL monitor_stalled: got no summary, expected summary within 5 cycles");
    $fatal(1, "monitor did not terminate");
  end

endmodule
